// File: rtl/dostring_wave_band_if.sv
// LED word channel between the wave generator and the doled SPI driver.
// The generator drives one word per led_start pulse; the driver answers with led_busy.
interface dostring_wave_band_if #(
  parameter int COLOR_W = 8
);
  logic               led_start;
  logic [1:0]         led_type;
  logic [COLOR_W-1:0] led_blue;
  logic [COLOR_W-1:0] led_green;
  logic [COLOR_W-1:0] led_red;
  logic               led_busy;

  modport master (
    output led_start, led_type, led_blue, led_green, led_red,
    input  led_busy
  );

  modport slave (
    input  led_start, led_type, led_blue, led_green, led_red,
    output led_busy
  );
endinterface

// File: rtl/dostring_wave_band.sv
// Wand frame builder: START, NUM_LEDS rotating-rainbow LED words with a bouncing white band, END.
// Each word takes WAIT/LOAD/START/HOLD (4+ cycles); stalls in WAIT for as long as led_busy is high.
module dostring_wave_band #(
  parameter int NUM_LEDS   = 47,
  parameter int COLOR_W    = 8,
  parameter int MAX_COLOR  = 200,
  parameter int STAGE_LEN  = 30,
  parameter int COLOR_STEP = 7,
  parameter int BAND_W     = 3
) (
  input  logic                        wavegen_clk,
  input  logic                        wavegen_reset_n,
  input  logic                        run,
  input  logic                        mode,
  dostring_wave_band_if.master        led,
  output logic                        frame_done,
  output logic [$clog2(NUM_LEDS)-1:0] band_pos
);
  localparam int IW  = $clog2(NUM_LEDS + 3);
  localparam int SW  = $clog2(STAGE_LEN + 1);
  localparam int RW  = COLOR_W + 8;
  localparam int BPW = $clog2(NUM_LEDS);

  localparam logic [RW-1:0]      MAX_R      = RW'(MAX_COLOR);
  localparam logic [RW-1:0]      STEP_R     = RW'(COLOR_STEP);
  localparam logic [RW-1:0]      CH_FULL    = RW'({COLOR_W{1'b1}});
  localparam logic [COLOR_W-1:0] WHITE      = COLOR_W'(MAX_COLOR);
  localparam logic [IW-1:0]      LAST_IDX   = IW'(NUM_LEDS + 1);
  localparam logic [IW-1:0]      DONE_IDX   = IW'(NUM_LEDS + 2);
  localparam logic [BPW-1:0]     BAND_MAX   = BPW'(NUM_LEDS - BAND_W);
  localparam logic [SW-1:0]      STAGE_LAST = SW'(STAGE_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_START, S_HOLD, S_FRAME_END} state_t;
  typedef enum logic [1:0] {CH_ZERO, CH_ASCEND, CH_DESCEND} ch_t;

  function automatic ch_t ch_next(ch_t s);
    case (s)
      CH_ZERO:   ch_next = CH_ASCEND;
      CH_ASCEND: ch_next = CH_DESCEND;
      default:   ch_next = CH_ZERO;
    endcase
  endfunction

  function automatic logic [COLOR_W-1:0] ch_val(ch_t s, logic [RW-1:0] r);
    logic [RW-1:0] v;
    case (s)
      CH_ZERO:   v = '0;
      CH_ASCEND: v = r;
      default:   v = MAX_R - r;
    endcase
    ch_val = (v > CH_FULL) ? {COLOR_W{1'b1}} : v[COLOR_W-1:0];
  endfunction

  state_t          state;
  logic [IW-1:0]   idx;
  logic            mode_q;
  logic            band_up;
  logic [SW-1:0]   stage_count;
  ch_t             st_b, st_g, st_r;

  logic [RW-1:0]      prod, ramp;
  logic [IW:0]        li, bp, be;
  logic [1:0]         nxt_type;
  logic [COLOR_W-1:0] nxt_b, nxt_g, nxt_r;

  // Word contents are a pure function of the word index and the per-frame state.
  always_comb begin
    prod     = RW'(stage_count) * STEP_R;
    ramp     = (prod > MAX_R) ? MAX_R : prod;
    li       = {1'b0, idx} - (IW+1)'(1);
    bp       = (IW+1)'(band_pos);
    be       = bp + (IW+1)'(BAND_W);
    nxt_type = 2'd1;
    nxt_b    = ch_val(st_b, ramp);
    nxt_g    = ch_val(st_g, ramp);
    nxt_r    = ch_val(st_r, ramp);
    if (idx == '0) begin
      nxt_type = 2'd0;
      nxt_b    = '0;
      nxt_g    = '0;
      nxt_r    = '0;
    end else if (idx == LAST_IDX) begin
      nxt_type = 2'd2;
      nxt_b    = '1;
      nxt_g    = '1;
      nxt_r    = '1;
    end else if (mode_q && li >= bp) begin
      if (li < be) begin
        nxt_b = WHITE;
        nxt_g = WHITE;
        nxt_r = WHITE;
      end else begin
        nxt_b = ch_val(ch_next(st_b), ramp);
        nxt_g = ch_val(ch_next(st_g), ramp);
        nxt_r = ch_val(ch_next(st_r), ramp);
      end
    end
  end

  always_ff @(posedge wavegen_clk or negedge wavegen_reset_n) begin
    if (!wavegen_reset_n) begin
      state         <= S_IDLE;
      idx           <= '0;
      mode_q        <= 1'b0;
      band_up       <= 1'b1;
      band_pos      <= '0;
      stage_count   <= '0;
      st_b          <= CH_DESCEND;
      st_g          <= CH_ASCEND;
      st_r          <= CH_ZERO;
      frame_done    <= 1'b0;
      led.led_start <= 1'b0;
      led.led_type  <= 2'd0;
      led.led_blue  <= '0;
      led.led_green <= '0;
      led.led_red   <= '0;
    end else begin
      led.led_start <= 1'b0;
      frame_done    <= 1'b0;
      case (state)
        S_IDLE: if (run) begin
          mode_q <= mode;
          idx    <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: if (!led.led_busy) state <= S_LOAD;
        S_LOAD: begin
          led.led_type  <= nxt_type;
          led.led_blue  <= nxt_b;
          led.led_green <= nxt_g;
          led.led_red   <= nxt_r;
          led.led_start <= 1'b1;
          state         <= S_START;
        end
        S_START: begin
          idx   <= idx + IW'(1);
          state <= S_HOLD;
        end
        // The driver needs a cycle to raise busy, so it is not sampled here.
        S_HOLD: begin
          if (idx == DONE_IDX) begin
            frame_done <= 1'b1;
            state      <= S_FRAME_END;
          end else begin
            state <= S_WAIT;
          end
        end
        S_FRAME_END: begin
          if (stage_count == STAGE_LAST) begin
            stage_count <= '0;
            st_b        <= ch_next(st_b);
            st_g        <= ch_next(st_g);
            st_r        <= ch_next(st_r);
          end else begin
            stage_count <= stage_count + SW'(1);
          end
          // Reverse on reaching an end so the endpoint is shown for a single frame.
          if (mode_q) begin
            if (band_up) begin
              if (band_pos == BAND_MAX) begin
                band_pos <= band_pos - BPW'(1);
                band_up  <= 1'b0;
              end else begin
                band_pos <= band_pos + BPW'(1);
              end
            end else begin
              if (band_pos == '0) begin
                band_pos <= BPW'(1);
                band_up  <= 1'b1;
              end else begin
                band_pos <= band_pos - BPW'(1);
              end
            end
          end
          if (run) begin
            idx    <= '0;
            mode_q <= mode;
            state  <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
